// File: rtl/instruction_sequencer.sv
// instruction_sequencer: four-step instruction sequencer that owns the program
// counter and the single memory port. Between instructions it can hand the
// port to one external requester for a bounded burst, and it can park the
// core in a halted state where the requester may use the port freely.

module instruction_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int unsigned MAX_EXT_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_ready,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    input  logic        halt_request,
    input  logic        resume,
    input  logic        ext_req,
    output logic [1:0]  step,
    output logic [15:0] pc,
    output logic        commit,
    output logic        ext_grant,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_S0     = 3'd0,
        ST_S1     = 3'd1,
        ST_S2     = 3'd2,
        ST_S3     = 3'd3,
        ST_EXT    = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    // Burst length limit, narrowed once to the counter width (legal range 1-15).
    localparam logic [3:0] EXT_LIMIT = 4'(MAX_EXT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  ext_count;
    logic        halt_grant;

    // State register; reset aborts any instruction or burst immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_S0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: wait states in S0/S2, commit decisions in S3,
    // bounded external bursts, and resume out of HALTED.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_S0: begin
                if (mem_ready) state_next = ST_S1;
            end
            ST_S1: begin
                state_next = ST_S2;
            end
            ST_S2: begin
                if (mem_ready) state_next = ST_S3;
            end
            ST_S3: begin
                if (halt_request)  state_next = ST_HALTED;
                else if (ext_req)  state_next = ST_EXT;
                else               state_next = ST_S0;
            end
            ST_EXT: begin
                if (!ext_req || (ext_count >= EXT_LIMIT)) state_next = ST_S0;
            end
            ST_HALTED: begin
                if (resume) state_next = ST_S0;
            end
            default: begin
                state_next = ST_S0;
            end
        endcase
    end

    // Output decode from registered state only, so no input reaches an output
    // combinationally; EXT and HALTED both present step 3 without a commit.
    always_comb begin
        step      = 2'd3;
        commit    = 1'b0;
        ext_grant = 1'b0;
        halted    = 1'b0;
        unique case (state)
            ST_S0:     step = 2'd0;
            ST_S1:     step = 2'd1;
            ST_S2:     step = 2'd2;
            ST_S3:     commit = 1'b1;
            ST_EXT:    ext_grant = 1'b1;
            ST_HALTED: begin
                halted    = 1'b1;
                ext_grant = halt_grant;
            end
            default:   step = 2'd3;
        endcase
    end

    // Program counter advances (or jumps) only on the commit edge, including
    // when the instruction halts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (state == ST_S3) begin
            pc <= pc_load ? pc_load_value : pc + 16'd1;
        end
    end

    // Burst counter: 1 on the first EXT cycle, counting up while the burst
    // continues, and cleared whenever the core owns the port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ext_count <= 4'd0;
        end else if (state_next == ST_EXT) begin
            ext_count <= (state == ST_EXT) ? ext_count + 4'd1 : 4'd1;
        end else begin
            ext_count <= 4'd0;
        end
    end

    // While halted the grant simply tracks the request one cycle late; resume
    // drops it on the same edge that leaves HALTED.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            halt_grant <= 1'b0;
        end else if ((state == ST_HALTED) && !resume) begin
            halt_grant <= ext_req;
        end else begin
            halt_grant <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed scenarios plus randomized traffic for
// instruction_sequencer, checked cycle by cycle against a behavioural model.

module tb_instruction_sequencer;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int          MAX_EXT   = 4;

    logic        clock;
    logic        reset_n;
    logic        mem_ready;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        halt_request;
    logic        resume;
    logic        ext_req;
    logic [1:0]  step;
    logic [15:0] pc;
    logic        commit;
    logic        ext_grant;
    logic        halted;

    int vectorCount = 0;
    int missCount   = 0;

    // Behavioural model: where the core is in its instruction, how many
    // cycles of the current external burst have elapsed (0 = no burst),
    // whether the core is parked, and the registered halted-mode grant.
    int          modelPhase;
    int          modelBurst;
    bit          modelHalted;
    bit          modelHaltGrant;
    logic [15:0] modelPc;

    instruction_sequencer #(
        .RESET_PC       (RESET_PC),
        .MAX_EXT_CYCLES (MAX_EXT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_ready     (mem_ready),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .halt_request  (halt_request),
        .resume        (resume),
        .ext_req       (ext_req),
        .step          (step),
        .pc            (pc),
        .commit        (commit),
        .ext_grant     (ext_grant),
        .halted        (halted)
    );

    // 10-unit clock; checks and stimulus happen on the falling edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelPhase     = 0;
        modelBurst     = 0;
        modelHalted    = 1'b0;
        modelHaltGrant = 1'b0;
        modelPc        = RESET_PC;
    endtask

    // Compare every DUT output against what the model says this cycle shows.
    task automatic checkAll();
        int  expStep;
        bit  expCommit;
        bit  expGrant;
        expStep   = (modelHalted || modelBurst > 0) ? 3 : modelPhase;
        expCommit = !modelHalted && modelBurst == 0 && modelPhase == 3;
        expGrant  = (modelBurst > 0) || (modelHalted && modelHaltGrant);
        checkOutput("step",      32'(step),      32'(expStep));
        checkOutput("pc",        32'(pc),        32'(modelPc));
        checkOutput("commit",    32'(commit),    32'(expCommit));
        checkOutput("ext_grant", 32'(ext_grant), 32'(expGrant));
        checkOutput("halted",    32'(halted),    32'(modelHalted));
    endtask

    // One cycle: check outputs, drive inputs, advance the model across the
    // coming rising edge, then wait for the next falling edge.
    task automatic applyStimulus(input bit mr, input bit ld, input logic [15:0] val,
                                 input bit hr, input bit rs, input bit er);
        checkAll();
        mem_ready     = mr;
        pc_load       = ld;
        pc_load_value = val;
        halt_request  = hr;
        resume        = rs;
        ext_req       = er;
        if (modelHalted) begin
            if (rs) begin
                modelHalted    = 1'b0;
                modelHaltGrant = 1'b0;
                modelPhase     = 0;
            end else begin
                modelHaltGrant = er;
            end
        end else if (modelBurst > 0) begin
            if (!er || modelBurst == MAX_EXT) begin
                modelBurst = 0;
                modelPhase = 0;
            end else begin
                modelBurst++;
            end
        end else begin
            case (modelPhase)
                0: if (mr) modelPhase = 1;
                1: modelPhase = 2;
                2: if (mr) modelPhase = 3;
                default: begin
                    modelPc    = ld ? val : 16'((32'(modelPc) + 1) % 65536);
                    modelPhase = 0;
                    if (hr) begin
                        modelHalted    = 1'b1;
                        modelHaltGrant = 1'b0;
                    end else if (er) begin
                        modelBurst = 1;
                    end
                end
            endcase
        end
        @(negedge clock);
    endtask

    // Asynchronous reset mid-cycle: outputs must collapse before any edge.
    task automatic pulseReset();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_step",      32'(step),      32'd0);
        checkOutput("rst_pc",        32'(pc),        32'(RESET_PC));
        checkOutput("rst_commit",    32'(commit),    32'd0);
        checkOutput("rst_ext_grant", 32'(ext_grant), 32'd0);
        checkOutput("rst_halted",    32'(halted),    32'd0);
        @(negedge clock);
        modelReset();
        reset_n = 1'b1;
    endtask

    task automatic runInstruction(input bit ld, input logic [15:0] val, input bit hr, input bit er);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, ld, val, hr, 0, er);
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_ready     = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 16'h0;
        halt_request  = 1'b0;
        resume        = 1'b0;
        ext_req       = 1'b0;
        modelReset();
        repeat (2) @(negedge clock);
        checkOutput("reset_hold_step", 32'(step), 32'd0);
        checkOutput("reset_hold_pc",   32'(pc),   32'(RESET_PC));
        reset_n = 1'b1;

        $display("[TB] free run");
        repeat (3) runInstruction(0, 16'h0, 0, 0);
        checkOutput("free_run_pc", 32'(pc), 32'h0003);

        $display("[TB] wait states");
        repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        checkOutput("wait_pc", 32'(pc), 32'h0004);

        $display("[TB] jump and wrap");
        runInstruction(1, 16'h1234, 0, 0);
        checkOutput("jump_pc", 32'(pc), 32'h1234);
        runInstruction(1, 16'hFFFF, 0, 0);
        runInstruction(0, 16'h0, 0, 0);
        checkOutput("wrap_pc", 32'(pc), 32'h0000);

        $display("[TB] external burst held and dropped");
        repeat (24) applyStimulus(1, 0, 16'h0, 0, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        checkOutput("burst_drop_step", 32'(step), 32'd0);

        $display("[TB] halt with pending request");
        runInstruction(0, 16'h0, 1, 1);
        checkOutput("halt_entry", 32'(halted), 32'd1);
        repeat (4) applyStimulus(0, 0, 16'h0, 0, 0, 1);
        checkOutput("halt_grant", 32'(ext_grant), 32'd1);
        applyStimulus(1, 0, 16'h0, 0, 1, 1);
        checkOutput("resume_step", 32'(step), 32'd0);

        $display("[TB] reset in S2 and in EXT");
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, 0);
        applyStimulus(0, 0, 16'h0, 0, 0, 0);
        checkOutput("pre_reset_s2", 32'(step), 32'd2);
        pulseReset();
        runInstruction(0, 16'h0, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, 1);
        checkOutput("pre_reset_ext", 32'(ext_grant), 32'd1);
        pulseReset();
        applyStimulus(1, 0, 16'h0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) begin
                pulseReset();
            end
            applyStimulus($urandom_range(0, 9) < 7,
                          $urandom_range(0, 3) == 0,
                          16'($urandom),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1);
        end
        checkAll();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Step sequencer and memory-port owner for the core. Generates the 2-bit `step` that drives the instruction loader and downstream datapath, holds and advances the program counter, stretches steps for memory wait states, and shares the single memory port with one external requester (DMA/debug). It also enters and leaves the halted state.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `MAX_EXT_CYCLES`, 4: maximum consecutive external-grant cycles inserted between two instructions while running. Range 1–15.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_ready` in 1: memory has completed the current access. Sampled only in steps 0 and 2.
- `pc_load` in 1: datapath requests a jump. Sampled at commit.
- `pc_load_value` in 16: jump target.
- `halt_request` in 1: the current instruction halts. Sampled at commit.
- `resume` in 1: leave HALTED.
- `ext_req` in 1: external requester wants the memory port.
- `step` out 2: current step, 0=fetch, 1=decode, 2=mem/execute, 3=writeback.
- `pc` out 16: current program counter; feeds the loader read address.
- `commit` out 1: one-cycle pulse on the last cycle of step 3.
- `ext_grant` out 1: the external requester owns the memory port this cycle.
- `halted` out 1: the core is in HALTED.

## Operation
- States: S0, S1, S2, S3, EXT, HALTED. `step` = 0/1/2/3 in S0–S3. `step` = 3 in EXT and HALTED, with `commit` = 0.
- S0: stays in S0 while `mem_ready` = 0; goes to S1 when `mem_ready` = 1.
- S1: always goes to S2.
- S2: stays in S2 while `mem_ready` = 0; goes to S3 when `mem_ready` = 1.
- S3: lasts one cycle with `commit` = 1. On that edge:
  - `pc` ← `pc_load ? pc_load_value : pc + 1`, modulo 2^16, so 16'hFFFF + 1 = 16'h0000.
  - Next state is HALTED if `halt_request` = 1; otherwise EXT if `ext_req` = 1; otherwise S0.
- EXT: `ext_grant` = 1. A cycle counter starts at 1 on entry.
  - Returns to S0 when `ext_req` = 0 or the counter reaches `MAX_EXT_CYCLES`.
  - Always returns to S0 after at most `MAX_EXT_CYCLES` cycles, so the core is guaranteed one instruction between external bursts.
  - `ext_req` still high on the return is served again at the next commit.
- HALTED: `halted` = 1; `ext_grant` follows `ext_req` registered, one cycle late. `pc` does not change. `resume` = 1 goes to S0 and clears `ext_grant` on the same edge; `resume` wins over `ext_req`.
- Simultaneous events at commit:
  - `halt_request` beats `ext_req`; the requester is served from HALTED.
  - `pc_load` is applied even when halting.
- `ext_grant` is 0 in S0–S3. The core never shares the port within an instruction.
- `mem_ready` is ignored in S1, S3, EXT and HALTED.

## Timing
- Reset values, asserted asynchronously on `reset_n` low and held until the first rising edge after release:
  - state S0, `step` = 0, `pc` = `RESET_PC`.
  - `commit` = 0, `ext_grant` = 0, `halted` = 0, EXT counter = 0.
- Reset mid-instruction or mid-EXT aborts immediately. `ext_grant` drops asynchronously.
- Zero-wait instruction takes 4 cycles: S0, S1, S2, S3. Each wait cycle adds one.
- The new `pc` is visible in the first cycle of the next S0.
- From `ext_req` at commit, `ext_grant` rises 1 cycle later (EXT entry).
- From `resume`, `step` = 0 in the next cycle.
- All outputs are registered or decoded from registered state. No combinational input-to-output paths.

## Test plan
- Reset then free run, `mem_ready` = 1, no jumps: `step` cycles 0,1,2,3; `commit` every 4th cycle; `pc` goes 0000, 0001, 0002 at each new S0.
- `mem_ready` = 0 for 3 cycles in S0 and 2 cycles in S2: instruction takes 9 cycles; `step` holds; `pc` advances by exactly 1.
- `pc_load` = 1 with value 16'h1234 at commit: next S0 has `pc` = 1234. With `pc` = FFFF and no load: next `pc` = 0000.
- `ext_req` held high continuously, `MAX_EXT_CYCLES` = 4: pattern is 4 core cycles then 4 `ext_grant` cycles, repeating. `ext_req` dropped after 2 grant cycles: S0 follows immediately.
- `halt_request` and `ext_req` both high at commit:
  - `halted` = 1 next cycle; `ext_grant` rises one cycle after that and stays high.
  - Pulse `resume`: `ext_grant` = 0, `halted` = 0, `step` = 0 on the following cycle.
- `reset_n` pulsed low during S2 and during EXT: all outputs return to reset values immediately; the first post-release cycle is S0 with `pc` = `RESET_PC`.
